// File: rtl/pe_id_cfg_loader_if.sv
// Config bus from the ID loader into the PE-array multicast-controller ID registers.
// One entry per valid/ready handshake; fields are held while the sink stalls.
interface pe_id_cfg_loader_if #(
  parameter int XID_W = 5
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_type;
  logic [1:0]       cfg_kind;
  logic [2:0]       cfg_row;
  logic [2:0]       cfg_col;
  logic [XID_W-1:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_type,
    output cfg_kind,
    output cfg_row,
    output cfg_col,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_type,
    input  cfg_kind,
    input  cfg_row,
    input  cfg_col,
    input  cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/pe_id_cfg_loader.sv
// Snapshots the PE-array ID generator outputs on start and streams them, one
// entry per handshake, into the multicast-controller ID registers.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start; snapshot holds the previous layer
// S_SEND_Y  | Y-ID of row `row` for type `typ`
// S_SEND_X  | X-ID of (row, col) for type `typ`, row-major
// S_SEND_LN | single LN_config beat
// S_DONE    | one-cycle done pulse, start ignored
module pe_id_cfg_loader #(
  parameter int ROWS  = 6,
  parameter int COLS  = 8,
  parameter int XID_W = 5,
  parameter int YID_W = 3,
  parameter int LN_W  = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ROWS*COLS*XID_W-1:0]  filter_xid,
  input  logic [ROWS*YID_W-1:0]       filter_yid,
  input  logic [ROWS*COLS*XID_W-1:0]  ifmap_xid,
  input  logic [ROWS*YID_W-1:0]       ifmap_yid,
  input  logic [ROWS*COLS*XID_W-1:0]  ipsum_xid,
  input  logic [ROWS*YID_W-1:0]       ipsum_yid,
  input  logic [ROWS*COLS*XID_W-1:0]  opsum_xid,
  input  logic [ROWS*YID_W-1:0]       opsum_yid,
  input  logic [LN_W-1:0]             ln_config,
  pe_id_cfg_loader_if.master          cfg,
  output logic                        busy,
  output logic                        done
);

  localparam int NX   = ROWS * COLS;
  localparam int XI_W = (NX > 1) ? $clog2(NX) : 1;
  localparam logic [2:0] ROW_LAST = 3'(ROWS - 1);
  localparam logic [2:0] COL_LAST = 3'(COLS - 1);
  localparam logic [1:0] TYP_LAST = 2'd3;

  // Row/column counters share the 3-bit width of cfg_row/cfg_col.
  if (ROWS < 1 || ROWS > 8 || COLS < 1 || COLS > 8) begin : g_bad_geometry
    $error("pe_id_cfg_loader: ROWS and COLS must be within 1..8");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND_Y  = 3'd1,
    S_SEND_X  = 3'd2,
    S_SEND_LN = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] row, row_nxt;
  logic [2:0] col, col_nxt;
  logic [1:0] typ, typ_nxt;

  logic capture;
  logic sending;
  logic fire;

  logic [NX*XID_W-1:0]   snap_xid [4];
  logic [ROWS*YID_W-1:0] snap_yid [4];
  logic [LN_W-1:0]       snap_ln;

  logic [XID_W-1:0] x_tab [4][NX];
  logic [YID_W-1:0] y_tab [4][ROWS];
  logic [XI_W-1:0]  x_idx;

  assign capture = (state == S_IDLE) && start;
  assign sending = (state == S_SEND_Y) || (state == S_SEND_X) || (state == S_SEND_LN);
  assign fire    = sending && cfg.cfg_ready;

  // Unpack the flat snapshot buses into per-entry tables for the read mux.
  for (genvar t = 0; t < 4; t++) begin : g_tab_type
    for (genvar k = 0; k < NX; k++) begin : g_tab_x
      assign x_tab[t][k] = snap_xid[t][k*XID_W +: XID_W];
    end
    for (genvar r = 0; r < ROWS; r++) begin : g_tab_y
      assign y_tab[t][r] = snap_yid[t][r*YID_W +: YID_W];
    end
  end

  assign x_idx = XI_W'(row) * XI_W'(COLS) + XI_W'(col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      row     <= '0;
      col     <= '0;
      typ     <= '0;
      snap_ln <= '0;
      for (int t = 0; t < 4; t++) begin
        snap_xid[t] <= '0;
        snap_yid[t] <= '0;
      end
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
      typ   <= typ_nxt;
      if (capture) begin
        snap_xid[0] <= filter_xid;
        snap_xid[1] <= ifmap_xid;
        snap_xid[2] <= ipsum_xid;
        snap_xid[3] <= opsum_xid;
        snap_yid[0] <= filter_yid;
        snap_yid[1] <= ifmap_yid;
        snap_yid[2] <= ipsum_yid;
        snap_yid[3] <= opsum_yid;
        snap_ln     <= ln_config;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    typ_nxt   = typ;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SEND_Y;
          row_nxt   = '0;
          col_nxt   = '0;
          typ_nxt   = '0;
        end
      end
      S_SEND_Y: begin
        if (fire) begin
          if (row == ROW_LAST) begin
            state_nxt = S_SEND_X;
            row_nxt   = '0;
            col_nxt   = '0;
          end else begin
            row_nxt = row + 3'd1;
          end
        end
      end
      S_SEND_X: begin
        if (fire) begin
          if (col != COL_LAST) begin
            col_nxt = col + 3'd1;
          end else if (row != ROW_LAST) begin
            col_nxt = '0;
            row_nxt = row + 3'd1;
          end else begin
            row_nxt = '0;
            col_nxt = '0;
            if (typ == TYP_LAST) begin
              state_nxt = S_SEND_LN;
              typ_nxt   = '0;
            end else begin
              state_nxt = S_SEND_Y;
              typ_nxt   = typ + 2'd1;
            end
          end
        end
      end
      S_SEND_LN: begin
        if (fire) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Beat fields come straight from state, counters and snapshot, so they stay
  // put for as long as the sink holds ready low.
  always_comb begin
    cfg.cfg_valid = 1'b0;
    cfg.cfg_type  = '0;
    cfg.cfg_kind  = '0;
    cfg.cfg_row   = '0;
    cfg.cfg_col   = '0;
    cfg.cfg_data  = '0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      S_SEND_Y: begin
        cfg.cfg_valid = 1'b1;
        cfg.cfg_type  = typ;
        cfg.cfg_kind  = 2'd0;
        cfg.cfg_row   = row;
        cfg.cfg_data  = XID_W'(y_tab[typ][row]);
        busy          = 1'b1;
      end
      S_SEND_X: begin
        cfg.cfg_valid = 1'b1;
        cfg.cfg_type  = typ;
        cfg.cfg_kind  = 2'd1;
        cfg.cfg_row   = row;
        cfg.cfg_col   = col;
        cfg.cfg_data  = x_tab[typ][x_idx];
        busy          = 1'b1;
      end
      S_SEND_LN: begin
        cfg.cfg_valid = 1'b1;
        cfg.cfg_kind  = 2'd2;
        cfg.cfg_data  = XID_W'(snap_ln);
        busy          = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_pe_id_cfg_loader.sv
// Scoreboard bench for pe_id_cfg_loader: stimulus pushes expected beats,
// a negedge monitor pops and compares every handshake.
module tb_pe_id_cfg_loader;

  localparam int ROWS   = 6;
  localparam int COLS   = 8;
  localparam int XID_W  = 5;
  localparam int YID_W  = 3;
  localparam int LN_W   = 5;
  localparam int NX     = ROWS * COLS;
  localparam int NBEATS = 4 * (ROWS + NX) + 1;

  typedef struct packed {
    logic [1:0]       typ;
    logic [1:0]       kind;
    logic [2:0]       row;
    logic [2:0]       col;
    logic [XID_W-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic [NX*XID_W-1:0]   xin [4];
  logic [ROWS*YID_W-1:0] yin [4];
  logic [LN_W-1:0]       ln;

  always #5 clk = ~clk;

  pe_id_cfg_loader_if #(.XID_W(XID_W)) cfg ();

  pe_id_cfg_loader #(
    .ROWS(ROWS), .COLS(COLS), .XID_W(XID_W), .YID_W(YID_W), .LN_W(LN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .filter_xid (xin[0]),
    .filter_yid (yin[0]),
    .ifmap_xid  (xin[1]),
    .ifmap_yid  (yin[1]),
    .ipsum_xid  (xin[2]),
    .ipsum_yid  (yin[2]),
    .opsum_xid  (xin[3]),
    .opsum_yid  (yin[3]),
    .ln_config  (ln),
    .cfg        (cfg),
    .busy       (busy),
    .done       (done)
  );

  beat_t sb [$];
  beat_t rx_log [NBEATS];
  int    tests = 0;
  int    fails = 0;
  int    rx_cnt = 0;
  int    done_cnt = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    done_cyc = 0;
  bit    ready_rand = 1'b0;
  bit    hold_pending = 1'b0;
  beat_t held;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    cfg.cfg_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic beat_t cur_beat();
    return {cfg.cfg_type, cfg.cfg_kind, cfg.cfg_row, cfg.cfg_col, cfg.cfg_data};
  endfunction

  // Monitor: samples on the falling edge, ahead of the edge that transfers.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending)
        check("hold_stable", 32'({cfg.cfg_valid, cur_beat()}), 32'({1'b1, held}));
      hold_pending = cfg.cfg_valid && !cfg.cfg_ready;
      held = cur_beat();
      if (cfg.cfg_valid && cfg.cfg_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_beat: got %h expected none", cur_beat());
        end else begin
          check($sformatf("beat%0d", rx_cnt), 32'(cur_beat()), 32'(sb.pop_front()));
        end
        if (rx_cnt < NBEATS) rx_log[rx_cnt] = cur_beat();
        rx_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_quiet", 32'({cfg.cfg_valid, busy}), 32'd0);
      end
    end
  end

  task automatic fill_pattern(input int salt);
    for (int t = 0; t < 4; t++) begin
      xin[t] = '0;
      yin[t] = '0;
      for (int k = 0; k < NX; k++)
        xin[t] = xin[t] | ((NX*XID_W)'((k + 7*t + salt) % 31) << (k*XID_W));
      for (int r = 0; r < ROWS; r++)
        yin[t] = yin[t] | ((ROWS*YID_W)'((r + t + salt) % 8) << (r*YID_W));
    end
    ln = LN_W'((20 + salt) % 32);
  endtask

  task automatic push_expected();
    logic [NX*XID_W-1:0]   xs;
    logic [ROWS*YID_W-1:0] ys;
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < ROWS; r++) begin
        ys = yin[t] >> (r*YID_W);
        sb.push_back({2'(t), 2'd0, 3'(r), 3'd0, XID_W'(ys[YID_W-1:0])});
      end
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          xs = xin[t] >> ((r*COLS + c)*XID_W);
          sb.push_back({2'(t), 2'd1, 3'(r), 3'(c), xs[XID_W-1:0]});
        end
    end
    sb.push_back({2'd0, 2'd2, 3'd0, 3'd0, XID_W'(ln)});
  endtask

  task automatic begin_stream();
    push_expected();
    rx_cnt   = 0;
    done_cnt = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    start_cyc = cyc;
    check("first_valid_busy", 32'({cfg.cfg_valid, busy}), 32'd3);
  endtask

  task automatic wait_beats(input int n);
    int i;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk);
      #2;
      if (rx_cnt >= n) break;
    end
    if (i == 5000) check("wait_beats_timeout", 32'(rx_cnt), 32'(n));
  endtask

  task automatic wait_done(input bit pulse_start_in_done);
    int i;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt > 0) break;
    end
    if (i == 5000) check("wait_done_timeout", 32'(done_cnt), 32'd1);
    if (pulse_start_in_done) begin
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic finish_checks();
    check("beat_count", 32'(rx_cnt), 32'(NBEATS));
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg.cfg_ready = 1'b1;
    fill_pattern(0);
    repeat (3) @(posedge clk);
    #1 check("reset_outputs",
             32'({cfg.cfg_valid, busy, done, cfg.cfg_type, cfg.cfg_kind,
                  cfg.cfg_row, cfg.cfg_col, cfg.cfg_data}), 32'd0);
    @(negedge clk) rst = 1'b0;

    // 1: reference pattern, ready tied high
    fill_pattern(0);
    begin_stream();
    wait_done(1'b0);
    finish_checks();
    check("latency_217", 32'(done_cyc - start_cyc), 32'(NBEATS));
    check("beat0_fy_r0",   32'(rx_log[0]),   32'({2'd0, 2'd0, 3'd0, 3'd0, 5'd0}));
    check("beat6_fx_r0c0", 32'(rx_log[6]),   32'({2'd0, 2'd1, 3'd0, 3'd0, 5'd0}));
    check("beat53_fx_last",32'(rx_log[53]),  32'({2'd0, 2'd1, 3'd5, 3'd7, 5'd16}));
    check("beat54_iy_r0",  32'(rx_log[54]),  32'({2'd1, 2'd0, 3'd0, 3'd0, 5'd1}));
    check("beat216_ln",    32'(rx_log[216]), 32'({2'd0, 2'd2, 3'd0, 3'd0, 5'd20}));

    // 2: random backpressure
    fill_pattern(3);
    ready_rand = 1'b1;
    begin_stream();
    wait_done(1'b0);
    ready_rand = 1'b0;
    finish_checks();

    // 3: inputs change right after capture
    fill_pattern(5);
    begin_stream();
    fill_pattern(11);
    wait_done(1'b0);
    finish_checks();

    // 4: start while busy and during DONE is ignored
    fill_pattern(2);
    begin_stream();
    wait_beats(10);
    start = 1'b1;
    fill_pattern(9);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1'b1);
    finish_checks();
    repeat (6) @(negedge clk);
    #2;
    check("idle_after_done", 32'({cfg.cfg_valid, busy}), 32'd0);
    check("single_done", 32'(done_cnt), 32'd1);
    check("no_restart_beats", 32'(rx_cnt), 32'(NBEATS));

    // 5: reset mid-stream, then a fresh stream
    fill_pattern(4);
    begin_stream();
    wait_beats(100);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("rst_midstream_outputs",
             32'({cfg.cfg_valid, busy, done, cfg.cfg_type, cfg.cfg_kind,
                  cfg.cfg_row, cfg.cfg_col, cfg.cfg_data}), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_done_after_abort", 32'(done_cnt), 32'd0);
    fill_pattern(13);
    begin_stream();
    wait_done(1'b0);
    finish_checks();
    check("latency_after_rst", 32'(done_cyc - start_cyc), 32'(NBEATS));
    check("restart_beat0", 32'(rx_log[0]), 32'({2'd0, 2'd0, 3'd0, 3'd0, 5'd5}));

    // 6: sentinel IDs pass through untouched
    for (int t = 0; t < 4; t++) begin
      xin[t] = '1;
      yin[t] = '1;
    end
    ln = 5'd9;
    begin_stream();
    wait_done(1'b0);
    finish_checks();
    check("sentinel_y", 32'(rx_log[0]),  32'({2'd0, 2'd0, 3'd0, 3'd0, 5'd7}));
    check("sentinel_x", 32'(rx_log[60]), 32'({2'd1, 2'd1, 3'd0, 3'd0, 5'd31}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_id_cfg_loader.md
Name: pe_id_cfg_loader

Overview:
Sequential loader directly downstream of pe_array_id_generator. On start it snapshots the generator's combinational tag outputs: X/Y IDs for filter, ifmap, ipsum and opsum, plus LN_config. It then streams them one entry per handshake over a config bus into the PE-array multicast-controller ID registers. It lets the ID generator's inputs change freely once a layer's configuration has been captured.

Parameters:
ROWS, 6, PE array rows; Y-ID entries per type
COLS, 8, PE array columns; X-ID entries per type = ROWS*COLS
XID_W, 5, X-ID width
YID_W, 3, Y-ID width
LN_W, 5, LN_config width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to capture and stream; accepted only in IDLE
filter_xid  in  ROWS*COLS*XID_W  entry k=row*COLS+col at [k*XID_W +: XID_W]
filter_yid  in  ROWS*YID_W  row r at [r*YID_W +: YID_W]
ifmap_xid  in  ROWS*COLS*XID_W  as filter_xid
ifmap_yid  in  ROWS*YID_W  as filter_yid
ipsum_xid  in  ROWS*COLS*XID_W  as filter_xid
ipsum_yid  in  ROWS*YID_W  as filter_yid
opsum_xid  in  ROWS*COLS*XID_W  as filter_xid
opsum_yid  in  ROWS*YID_W  as filter_yid
ln_config  in  LN_W  LN bypass configuration
cfg_valid  out  1  beat valid
cfg_ready  in  1  sink ready; transfer when valid&ready
cfg_type  out  2  0 filter, 1 ifmap, 2 ipsum, 3 opsum (0 during LN beat)
cfg_kind  out  2  0 Y-ID, 1 X-ID, 2 LN_config
cfg_row  out  3  PE row (0 for LN beat)
cfg_col  out  3  PE column (0 for Y/LN beats)
cfg_data  out  XID_W  ID, zero-extended for Y-IDs and LN
busy  out  1  high from the capture cycle through the last handshake cycle
done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; snapshot registers cleared.
- States: IDLE, SEND_Y, SEND_X, SEND_LN, DONE.
- IDLE:
  - start=1 at edge N registers every ID input and ln_config into a snapshot.
  - busy=1 and cfg_valid=1 from edge N; first beat is filter Y row 0.
  - Inputs are not sampled again until the next accepted start.
- Order:
  - For type 0..3: SEND_Y rows 0..ROWS-1, then SEND_X row-major (row 0 col 0..COLS-1, row 1, ...).
  - Then one SEND_LN beat.
  - Total beats = 4*(ROWS+ROWS*COLS)+1 = 217 at defaults.
- Handshake:
  - A beat advances only on cfg_valid&cfg_ready.
  - While ready=0, valid stays 1 and all cfg_* fields stay stable.
  - No bubbles: with ready tied high, one beat per cycle, so the 217 beats occupy cycles N+1..N+217 after the start edge.
- Sentinel values (X=31, Y=7) are streamed unchanged; the sink treats them as never-match. Nothing is skipped.
- Transitions:
  - SEND_Y → SEND_X after row ROWS-1.
  - SEND_X → SEND_Y of next type after (ROWS-1, COLS-1).
  - SEND_X of type 3 → SEND_LN.
  - SEND_LN handshake → DONE.
- DONE: valid=0, busy=0, done=1 for exactly one cycle, then IDLE. start seen in DONE is ignored.
- start while busy is ignored; the snapshot is unchanged.
- Counters: row 0..ROWS-1, col 0..COLS-1, type 0..3. No wrap beyond the final beat. Counters reset to 0 on entering SEND_Y.
- Reset mid-stream aborts immediately: no done pulse; the next start restarts from filter Y row 0 with a fresh snapshot.

Test Plan:
- Defaults, ready=1, filter_xid entry k=k%31, yid row r=r, ln_config=20, start → 217 consecutive beats. Beat 0: type0 kind0 row0 data0. Beat 6: type0 kind1 row0 col0. Beat 54: type1 Y row0. Beat 216: kind2 data20. done pulses the following cycle.
- Random ready (~50%) → no lost, duplicated or reordered beats; fields held stable across every ready=0 cycle; still exactly 217 handshakes.
- Start, then change all ID inputs one cycle later → streamed data matches the values present at the start edge.
- start pulsed at beat 10 and again during DONE → ignored; beat count 217; single done pulse.
- Assert rst at beat 100 → outputs 0 within the reset assertion. Then start → first beat is filter Y row 0 from the new snapshot, with full 217 beats.
- Sentinel inputs (all X=31, Y=7) → streamed unchanged.
